// File: rtl/irq_sched.sv
// Machine-level interrupt scheduler: synchronizes the external IRQ, holds the software
// IRQ and the 64-bit timer, and drives a registered request/cause handshake to WB.
module irq_sched #(
   parameter int RSZ         = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk_in,
   input  logic           reset_in,
   input  logic           ext_irq_in,
   input  logic           msip_set_in,
   input  logic           msip_clr_in,
   input  logic           time_tick_in,
   input  logic           mtime_lo_wr,
   input  logic           mtime_hi_wr,
   input  logic           mtimecmp_lo_wr,
   input  logic           mtimecmp_hi_wr,
   input  logic [31:0]    wdata_in,
   input  logic [1:0]     mode_in,
   input  logic           mstatus_mie_in,
   input  logic           msie_in,
   input  logic           mtie_in,
   input  logic           meie_in,
   input  logic           irq_ack_in,
   input  logic           mret_in,
   output logic           mip_msip,
   output logic           mip_mtip,
   output logic           mip_meip,
   output logic           irq_req,
   output logic [RSZ-1:0] irq_cause,
   output logic [63:0]    mtime,
   output logic [63:0]    mtimecmp
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_SERVICE
   } state_t;

   localparam logic [3:0] CODE_MSI = 4'd3;
   localparam logic [3:0] CODE_MTI = 4'd7;
   localparam logic [3:0] CODE_MEI = 4'd11;

   state_t                 state_q, state_d;
   logic [RSZ-1:0]         cause_q, cause_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   msip_q, msip_d;
   logic [63:0]            mtime_q, mtime_d;
   logic [63:0]            mtimecmp_q, mtimecmp_d;

   logic                   eligible;
   logic                   msi_act, mti_act, mei_act, any_act;
   logic [RSZ-1:0]         sel_cause;

   // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], ext_irq_in};

      // Set has priority over clear when both strobes arrive together.
      msip_d = msip_q;
      if (msip_set_in)      msip_d = 1'b1;
      else if (msip_clr_in) msip_d = 1'b0;

      // A half write replaces the tick for that cycle; the untouched half holds.
      mtime_d = mtime_q;
      if (mtime_lo_wr || mtime_hi_wr) begin
         if (mtime_lo_wr) mtime_d[31:0]  = wdata_in;
         if (mtime_hi_wr) mtime_d[63:32] = wdata_in;
      end else if (time_tick_in) begin
         mtime_d = mtime_q + 64'd1;
      end

      mtimecmp_d = mtimecmp_q;
      if (mtimecmp_lo_wr) mtimecmp_d[31:0]  = wdata_in;
      if (mtimecmp_hi_wr) mtimecmp_d[63:32] = wdata_in;
   end

   assign mip_meip = sync_q[SYNC_STAGES-1];
   assign mip_msip = msip_q;
   assign mip_mtip = (mtime_q >= mtimecmp_q);

   assign eligible = (mode_in != 2'd3) | mstatus_mie_in;
   assign msi_act  = mip_msip & msie_in;
   assign mti_act  = mip_mtip & mtie_in;
   assign mei_act  = mip_meip & meie_in;
   assign any_act  = msi_act | mti_act | mei_act;

   // Fixed priority MEI > MSI > MTI, interrupt bit in the MSB.
   always_comb begin
      sel_cause          = '0;
      sel_cause[RSZ-1]   = 1'b1;
      if (mei_act)      sel_cause[3:0] = CODE_MEI;
      else if (msi_act) sel_cause[3:0] = CODE_MSI;
      else              sel_cause[3:0] = CODE_MTI;
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      unique case (state_q)
         ST_IDLE: begin
            if (eligible && any_act) begin
               state_d = ST_REQ;
               cause_d = sel_cause;
            end
         end
         // Cause stays frozen while requesting; ack beats a simultaneous withdraw.
         ST_REQ: begin
            if (irq_ack_in)                  state_d = ST_SERVICE;
            else if (!any_act || !eligible)  state_d = ST_IDLE;
         end
         ST_SERVICE: begin
            if (mret_in) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q    <= ST_IDLE;
         cause_q    <= '0;
         sync_q     <= '0;
         msip_q     <= 1'b0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
      end else begin
         state_q    <= state_d;
         cause_q    <= cause_d;
         sync_q     <= sync_d;
         msip_q     <= msip_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
      end
   end

   assign irq_req   = (state_q == ST_REQ);
   assign irq_cause = cause_q;
   assign mtime     = mtime_q;
   assign mtimecmp  = mtimecmp_q;

endmodule
